// File: rtl/aurora_pattern_pkg.sv
// aurora_pattern_pkg: shared types, constants and PRBS31 helpers for the
// Aurora Tx pattern generator.
package aurora_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_FIXED = 2'd0,
      MODE_USER  = 2'd1,
      MODE_COUNT = 2'd2,
      MODE_PRBS  = 2'd3
   } mode_e;

   localparam logic [1:0]  SYNC_NONE   = 2'b00;
   localparam logic [1:0]  SYNC_DATA   = 2'b01;
   localparam logic [1:0]  SYNC_CTRL   = 2'b10;
   localparam logic [7:0]  IDLE_BTF    = 8'h78;
   localparam logic [63:0] IDLE_BLOCK  = {IDLE_BTF, 56'h0};
   localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

   // Sequence view of x^31 + x^28 + 1: b[0..30] are the 31 stored bits
   // (oldest first, b[0] = state[30]); each new bit is b[n] ^ b[n+3].
   function automatic logic [94:0] prbs31_ext(input logic [30:0] state);
      logic [94:0] b;
      b = '0;
      for (int k = 0; k < 31; k++) b[k] = state[30-k];
      for (int k = 0; k < 64; k++) b[k+31] = b[k] ^ b[k+3];
      return b;
   endfunction

   // Next 64 generated bits, first generated bit in the MSB.
   function automatic logic [63:0] prbs31_word(input logic [30:0] state);
      logic [94:0] b;
      logic [63:0] w;
      b = prbs31_ext(state);
      w = '0;
      for (int k = 0; k < 64; k++) w[63-k] = b[k+31];
      return w;
   endfunction

   // Register contents after 64 bits have been generated.
   function automatic logic [30:0] prbs31_next(input logic [30:0] state);
      logic [94:0] b;
      logic [30:0] s;
      b = prbs31_ext(state);
      s = '0;
      for (int j = 0; j < 31; j++) s[j] = b[94-j];
      return s;
   endfunction

   function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
      int s;
      s = n % 64;
      return (x << s) | (x >> (64 - s));
   endfunction

endpackage

// File: rtl/prbs31_par64.sv
// prbs31_par64: registered PRBS31 (x^31 + x^28 + 1) producing 64 bits per step.
// q shows the word that the current step consumes; with reseed high it is the
// first word from the seed, so a restart can use it in the same cycle.
module prbs31_par64
   import aurora_pattern_pkg::*;
(
   input  logic        clk40,
   input  logic        rst_n,
   input  logic        step,
   input  logic        reseed,
   output logic [63:0] q
);

   logic [30:0] r_state;
   logic [30:0] w_base;

   // Reseed on request, and recover to the seed should the register ever be zero.
   always_comb begin
      w_base = r_state;
      if (reseed || (r_state == '0)) w_base = PRBS31_SEED;
   end

   assign q = prbs31_word(w_base);

   // State register: advance 64 bits per step, otherwise load the seed if requested.
   always_ff @(posedge clk40 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= PRBS31_SEED;
      end else if (step) begin
         r_state <= prbs31_next(w_base);
      end else begin
         r_state <= w_base;
      end
   end

endmodule

// File: rtl/aurora_tx_pattern_gen.sv
// aurora_tx_pattern_gen: multi-lane Aurora 64b/66b Tx test-pattern source.
// Every enabled lane advances together on the gearbox handshake so bonded
// lanes stay word-aligned. Optional bit-error injection is built when
// AURORA_PATTERN_ERR_INJECT_EN is defined.
module aurora_tx_pattern_gen
   import aurora_pattern_pkg::*;
#(
   parameter int          NUM_LANES   = 8,
   parameter int          DATA_W      = 64,
   parameter int          IDLE_PERIOD = 0,
   parameter logic [63:0] FIXED_WORD  = 64'hC0CA_C01A_CAFE_0000
) (
   input  logic                          clk40,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [1:0]                    mode,
   input  logic [DATA_W-1:0]             user_data,
   input  logic [NUM_LANES-1:0]          lane_en,
   input  logic [NUM_LANES-1:0]          gearbox_rdy,
   input  logic [NUM_LANES-1:0]          data_next,
`ifdef AURORA_PATTERN_ERR_INJECT_EN
   input  logic                          err_inject,
   input  logic [(NUM_LANES > 1 ? $clog2(NUM_LANES) : 1)-1:0] err_lane,
   output logic [15:0]                   err_count,
`endif
   output logic [NUM_LANES*DATA_W-1:0]   data_in,
   output logic [NUM_LANES*2-1:0]        sync,
   output logic [31:0]                   word_cnt,
   output logic [15:0]                   ctrl_cnt
);

   localparam bit          IDLE_EN     = (IDLE_PERIOD != 0);
   localparam logic [15:0] PERIOD_LAST = IDLE_EN ? 16'(IDLE_PERIOD - 1) : 16'd0;

   mode_e                        w_mode;
   mode_e                        r_mode_q;
   logic                         w_adv;
   logic                         w_restart;
   logic                         w_is_ctrl;
   logic                         w_data_adv;
   logic                         w_prbs_step;
   logic                         w_err_fire;
   logic [15:0]                  w_period_cur;
   logic [63:0]                  w_base_cur;
   logic [63:0]                  w_prbs_word;
   logic [NUM_LANES*DATA_W-1:0]  w_data_nxt;
   logic [NUM_LANES*2-1:0]       w_sync_nxt;

   logic [NUM_LANES*DATA_W-1:0]  r_data;
   logic [NUM_LANES*2-1:0]       r_sync;
   logic [31:0]                  r_word_cnt;
   logic [15:0]                  r_ctrl_cnt;
   logic [63:0]                  r_base;
   logic [15:0]                  r_period;

   assign w_mode = mode_e'(mode);

   // Lock-step handshake: every enabled lane must be ready and requesting;
   // an all-disabled mask never advances.
   always_comb begin
      w_adv = en & (&(gearbox_rdy | ~lane_en)) & (&(data_next | ~lane_en)) & (|lane_en);
      w_restart    = w_adv && (w_mode != r_mode_q);
      w_period_cur = w_restart ? 16'd0 : r_period;
      w_base_cur   = w_restart ? 64'd0 : r_base;
      w_is_ctrl    = IDLE_EN && (w_period_cur == PERIOD_LAST);
      w_data_adv   = w_adv && !w_is_ctrl;
      w_prbs_step  = w_data_adv && (w_mode == MODE_PRBS);
   end

   prbs31_par64 u_prbs (
      .clk40  (clk40),
      .rst_n  (rst_n),
      .step   (w_prbs_step),
      .reseed (w_restart),
      .q      (w_prbs_word)
   );

`ifdef AURORA_PATTERN_ERR_INJECT_EN
   logic        r_err_prev;
   logic        r_err_armed;
   logic [15:0] r_err_count;
   logic        w_err_rise;

   assign w_err_rise = err_inject & ~r_err_prev;
   // The one-shot only fires when the target lane actually carries data.
   assign w_err_fire = r_err_armed & w_data_adv & lane_en[err_lane];
   assign err_count  = r_err_count;

   // Rising-edge detect arms the one-shot; firing clears it unless re-armed.
   always_ff @(posedge clk40 or negedge rst_n) begin
      if (!rst_n) begin
         r_err_prev  <= 1'b0;
         r_err_armed <= 1'b0;
         r_err_count <= 16'd0;
      end else begin
         r_err_prev <= err_inject;
         if (w_err_rise) begin
            r_err_armed <= 1'b1;
         end else if (w_err_fire) begin
            r_err_armed <= 1'b0;
         end
         if (w_err_fire) r_err_count <= r_err_count + 16'd1;
      end
   end
`else
   assign w_err_fire = 1'b0;
`endif

   // Per-lane payload and sync header for the next advance.
   always_comb begin
      logic [63:0] v_word;
      w_data_nxt = '0;
      w_sync_nxt = '0;
      v_word     = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         v_word = '0;
         if (lane_en[i]) begin
            if (w_is_ctrl) begin
               v_word                = IDLE_BLOCK;
               w_sync_nxt[2*i +: 2]  = SYNC_CTRL;
            end else begin
               case (w_mode)
                  MODE_FIXED: v_word = FIXED_WORD;
                  MODE_USER:  v_word = user_data;
                  MODE_COUNT: v_word = w_base_cur + 64'(i);
                  default:    v_word = rotl64(w_prbs_word, 8*i);
               endcase
`ifdef AURORA_PATTERN_ERR_INJECT_EN
               if (w_err_fire && (int'(err_lane) == i)) v_word[0] = ~v_word[0];
`endif
               w_sync_nxt[2*i +: 2] = SYNC_DATA;
            end
         end else begin
            w_sync_nxt[2*i +: 2] = SYNC_NONE;
         end
         w_data_nxt[DATA_W*i +: DATA_W] = v_word;
      end
   end

   // Output and pattern state registers; everything holds when no advance.
   always_ff @(posedge clk40 or negedge rst_n) begin
      if (!rst_n) begin
         r_data     <= '0;
         r_sync     <= '0;
         r_word_cnt <= 32'd0;
         r_ctrl_cnt <= 16'd0;
         r_base     <= 64'd0;
         r_period   <= 16'd0;
         r_mode_q   <= MODE_FIXED;
      end else if (w_adv) begin
         r_data   <= w_data_nxt;
         r_sync   <= w_sync_nxt;
         r_mode_q <= w_mode;
         if (w_is_ctrl) begin
            r_ctrl_cnt <= r_ctrl_cnt + 16'd1;
         end else begin
            r_word_cnt <= r_word_cnt + 32'd1;
         end
         if (w_data_adv && (w_mode == MODE_COUNT)) begin
            r_base <= w_base_cur + 64'd1;
         end else begin
            r_base <= w_base_cur;
         end
         if (!IDLE_EN || w_is_ctrl) begin
            r_period <= 16'd0;
         end else begin
            r_period <= w_period_cur + 16'd1;
         end
      end
   end

   assign data_in  = r_data;
   assign sync     = r_sync;
   assign word_cnt = r_word_cnt;
   assign ctrl_cnt = r_ctrl_cnt;

endmodule

// File: tb/tb_aurora_tx_pattern_gen.sv
// tb_aurora_tx_pattern_gen: two generators (idle insertion off / every 4th
// word) driven by shared directed and random stimulus. A behavioural model
// pushes expected outputs per clock; a monitor pops and compares.
`timescale 1ns/1ps
module tb_aurora_tx_pattern_gen;

   localparam int          NL      = 8;
   localparam logic [63:0] FIXED_W = 64'hC0CA_C01A_CAFE_0000;
   localparam logic [63:0] CTRL_W  = 64'h7800_0000_0000_0000;
   localparam logic [63:0] PRBS_W0 = 64'h0000_000E_0000_00FC;
   localparam logic [30:0] SEED    = 31'h7FFF_FFFF;

   logic clk40 = 1'b0;
   always #5 clk40 = ~clk40;

   logic              rst_n;
   logic              en;
   logic [1:0]        mode;
   logic [63:0]       user_data;
   logic [NL-1:0]     lane_en;
   logic [NL-1:0]     gearbox_rdy;
   logic [NL-1:0]     data_next;
   logic              err_inject;
   logic [2:0]        err_lane;
   logic [NL*64-1:0]  data_a, data_b;
   logic [NL*2-1:0]   sync_a, sync_b;
   logic [31:0]       wc_a, wc_b;
   logic [15:0]       cc_a, cc_b;
`ifdef AURORA_PATTERN_ERR_INJECT_EN
   logic [15:0]       ec_a, ec_b;
`endif

   aurora_tx_pattern_gen #(.NUM_LANES(NL), .DATA_W(64), .IDLE_PERIOD(0)) u_dut_a (
      .clk40(clk40), .rst_n(rst_n), .en(en), .mode(mode), .user_data(user_data),
      .lane_en(lane_en), .gearbox_rdy(gearbox_rdy), .data_next(data_next),
`ifdef AURORA_PATTERN_ERR_INJECT_EN
      .err_inject(err_inject), .err_lane(err_lane), .err_count(ec_a),
`endif
      .data_in(data_a), .sync(sync_a), .word_cnt(wc_a), .ctrl_cnt(cc_a)
   );

   aurora_tx_pattern_gen #(.NUM_LANES(NL), .DATA_W(64), .IDLE_PERIOD(4)) u_dut_b (
      .clk40(clk40), .rst_n(rst_n), .en(en), .mode(mode), .user_data(user_data),
      .lane_en(lane_en), .gearbox_rdy(gearbox_rdy), .data_next(data_next),
`ifdef AURORA_PATTERN_ERR_INJECT_EN
      .err_inject(err_inject), .err_lane(err_lane), .err_count(ec_b),
`endif
      .data_in(data_b), .sync(sync_b), .word_cnt(wc_b), .ctrl_cnt(cc_b)
   );

   typedef struct {
      int               dut;
      logic [NL*64-1:0] data;
      logic [NL*2-1:0]  sync;
      logic [31:0]      wc;
      logic [15:0]      cc;
      logic [15:0]      ec;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state, one set per generator
   int               m_period [2];
   logic [1:0]       m_mode_q [2];
   logic [63:0]      m_base   [2];
   logic [30:0]      m_lfsr   [2];
   int               m_pidx   [2];
   logic [31:0]      m_wc     [2];
   logic [15:0]      m_cc     [2];
   logic [15:0]      m_ec     [2];
   logic             m_armed  [2];
   logic             m_prev   [2];
   logic [NL*64-1:0] m_data   [2];
   logic [NL*2-1:0]  m_sync   [2];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] lane(input logic [NL*64-1:0] v, input int i);
      return v[64*i +: 64];
   endfunction

   // Serial PRBS31 generator: one bit per shift, 64 shifts per word.
   task automatic prbs_gen(input logic [30:0] s_in, output logic [63:0] w, output logic [30:0] s_out);
      logic [30:0] s;
      logic        nb;
      s = s_in;
      w = '0;
      for (int k = 0; k < 64; k++) begin
         nb = s[30] ^ s[27];
         s  = {s[29:0], nb};
         w  = {w[62:0], nb};
      end
      s_out = s;
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      logic [63:0] r;
      r = '0;
      for (int b = 0; b < 64; b++) r[(b + n) % 64] = x[b];
      return r;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_mode_q[d] = 2'd0;
         m_base[d]   = '0;
         m_lfsr[d]   = SEED;
         m_pidx[d]   = 0;
         m_wc[d]     = '0;
         m_cc[d]     = '0;
         m_ec[d]     = '0;
         m_armed[d]  = 1'b0;
         m_prev[d]   = 1'b0;
         m_data[d]   = '0;
         m_sync[d]   = '0;
      end
   endtask

   // Predict what each generator shows after the coming clock edge.
   task automatic model_eval();
      bit adv;
      adv = en && (lane_en != '0);
      for (int i = 0; i < NL; i++)
         if (lane_en[i] && !(gearbox_rdy[i] && data_next[i])) adv = 0;
      for (int d = 0; d < 2; d++) begin
         bit          ctrl;
         bit          fire;
         logic [63:0] prbs_w;
         logic [30:0] nl;
         logic [63:0] w;
         logic [1:0]  s;
         exp_t        e;
         ctrl = 0;
         fire = 0;
         if (adv) begin
            if (mode != m_mode_q[d]) begin
               m_base[d] = '0;
               m_lfsr[d] = SEED;
               m_pidx[d] = 0;
            end
            m_mode_q[d] = mode;
            ctrl = (m_period[d] != 0) && (m_pidx[d] == m_period[d] - 1);
            if (m_period[d] != 0) m_pidx[d] = (m_pidx[d] + 1) % m_period[d];
            prbs_w = '0;
            if (!ctrl && mode == 2'd3) begin
               prbs_gen(m_lfsr[d], prbs_w, nl);
               m_lfsr[d] = nl;
            end
            fire = !ctrl && m_armed[d] && lane_en[err_lane];
            for (int i = 0; i < NL; i++) begin
               if (!lane_en[i]) begin
                  w = '0; s = 2'b00;
               end else if (ctrl) begin
                  w = CTRL_W; s = 2'b10;
               end else begin
                  case (mode)
                     2'd0:    w = FIXED_W;
                     2'd1:    w = user_data;
                     2'd2:    w = m_base[d] + 64'(i);
                     default: w = rotl(prbs_w, 8*i);
                  endcase
                  if (fire && int'(err_lane) == i) w[0] = ~w[0];
                  s = 2'b01;
               end
               m_data[d][64*i +: 64] = w;
               m_sync[d][2*i +: 2]   = s;
            end
            if (ctrl) m_cc[d] = m_cc[d] + 16'd1;
            else begin
               m_wc[d] = m_wc[d] + 32'd1;
               if (mode == 2'd2) m_base[d] = m_base[d] + 64'd1;
            end
            if (fire) m_ec[d] = m_ec[d] + 16'd1;
         end
         if (err_inject && !m_prev[d]) m_armed[d] = 1'b1;
         else if (fire) m_armed[d] = 1'b0;
         m_prev[d] = err_inject;
         e.dut = d; e.data = m_data[d]; e.sync = m_sync[d];
         e.wc = m_wc[d]; e.cc = m_cc[d]; e.ec = m_ec[d];
         exp_q.push_back(e);
      end
   endtask

   task automatic step();
      model_eval();
      @(posedge clk40);
      #2;
   endtask

   task automatic cmp_out(input exp_t e, input logic [NL*64-1:0] dv, input logic [NL*2-1:0] sv,
                          input logic [31:0] wc, input logic [15:0] cc, input logic [15:0] ec);
      string tag;
      tag = (e.dut == 0) ? "a" : "b";
      for (int i = 0; i < NL; i++) chk($sformatf("sb_data_%s_l%0d", tag, i), lane(dv, i), lane(e.data, i));
      chk({"sb_sync_", tag}, 64'(sv), 64'(e.sync));
      chk({"sb_word_cnt_", tag}, 64'(wc), 64'(e.wc));
      chk({"sb_ctrl_cnt_", tag}, 64'(cc), 64'(e.cc));
`ifdef AURORA_PATTERN_ERR_INJECT_EN
      chk({"sb_err_count_", tag}, 64'(ec), 64'(e.ec));
`else
      if (ec != 16'd0) chk({"sb_err_count_", tag}, 64'(ec), 64'(e.ec));
`endif
   endtask

   // Monitor: compare every expectation due at this edge.
   initial begin
      forever begin
         @(posedge clk40);
         #1;
         while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
`ifdef AURORA_PATTERN_ERR_INJECT_EN
            if (e.dut == 0) cmp_out(e, data_a, sync_a, wc_a, cc_a, ec_a);
            else            cmp_out(e, data_b, sync_b, wc_b, cc_b, ec_b);
`else
            if (e.dut == 0) cmp_out(e, data_a, sync_a, wc_a, cc_a, 16'd0);
            else            cmp_out(e, data_b, sync_b, wc_b, cc_b, 16'd0);
`endif
         end
      end
   end

   // Drop reset between edges and check the outputs clear without a clock.
   task automatic apply_reset();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 10) begin
         @(posedge clk40); #2;
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
         exp_q.delete();
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_data_a", 64'(|data_a), 64'd0);
      chk("rst_data_b", 64'(|data_b), 64'd0);
      chk("rst_sync_a", 64'(sync_a), 64'd0);
      chk("rst_sync_b", 64'(sync_b), 64'd0);
      chk("rst_wc_a", 64'(wc_a), 64'd0);
      chk("rst_cc_b", 64'(cc_b), 64'd0);
      model_reset();
      @(posedge clk40); #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1; en = 1'b0; mode = 2'd0; user_data = '0;
      lane_en = '1; gearbox_rdy = '1; data_next = '1;
      err_inject = 1'b0; err_lane = 3'd0;
      m_period[0] = 0;
      m_period[1] = 4;
      model_reset();
      repeat (2) @(posedge clk40);
      #2;
      apply_reset();

      // FIXED, three advances
      en = 1'b1; mode = 2'd0;
      repeat (3) step();
      for (int i = 0; i < NL; i++) chk($sformatf("fixed_l%0d", i), lane(data_a, i), FIXED_W);
      chk("fixed_sync", 64'(sync_a), 64'h5555);
      chk("fixed_wc", 64'(wc_a), 64'd3);

      // COUNT with restart
      mode = 2'd2;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("count_l0", lane(data_a, 0), 64'(k));
         chk("count_l3", lane(data_a, 3), 64'(3 + k));
      end
      mode = 2'd0; step();
      mode = 2'd2; step();
      chk("count_restart_l0", lane(data_a, 0), 64'd0);
      chk("count_restart_l7", lane(data_a, 7), 64'd7);

      // lane mask: lane 2 blocks, lane 5 is disabled and ignored
      lane_en = 8'h0F; data_next = 8'hDB;
      step();
      chk("mask_block_wc", 64'(wc_a), 64'd9);
      data_next = 8'hDF;
      step();
      chk("mask_adv_wc", 64'(wc_a), 64'd10);
      chk("mask_l0", lane(data_a, 0), 64'd1);
      for (int i = 4; i < NL; i++) chk($sformatf("mask_off_l%0d", i), lane(data_a, i), 64'd0);
      chk("mask_sync", 64'(sync_a), 64'h0055);

      // idle insertion on the IDLE_PERIOD=4 generator
      apply_reset();
      lane_en = '1; data_next = '1; mode = 2'd2; en = 1'b1;
      begin
         int val;
         val = 0;
         for (int k = 0; k < 8; k++) begin
            step();
            if (k == 3 || k == 7) begin
               chk("idle_ctrl_data", lane(data_b, 0), CTRL_W);
               chk("idle_ctrl_sync", 64'(sync_b[1:0]), 64'h2);
            end else begin
               chk("idle_data", lane(data_b, 0), 64'(val));
               chk("idle_data_sync", 64'(sync_b[1:0]), 64'h1);
               val++;
            end
         end
      end
      chk("idle_cc", 64'(cc_b), 64'd2);
      chk("idle_wc", 64'(wc_b), 64'd6);
      chk("noidle_wc", 64'(wc_a), 64'd8);

      // PRBS from seed, then async reset mid-stream
      mode = 2'd3;
      step();
      chk("prbs_l0", lane(data_a, 0), PRBS_W0);
      chk("prbs_l1", lane(data_a, 1), 64'h0000_0E00_0000_FC00);
      step();
      apply_reset();
      step();
      chk("prbs_after_rst_l0", lane(data_a, 0), PRBS_W0);

`ifdef AURORA_PATTERN_ERR_INJECT_EN
      mode = 2'd0; step();
      err_lane = 3'd2; err_inject = 1'b1; step();
      err_inject = 1'b0; step();
      chk("err_word", lane(data_a, 2), 64'hC0CA_C01A_CAFE_0001);
      step();
      chk("err_clean", lane(data_a, 2), FIXED_W);
      chk("err_count", 64'(ec_a), 64'd1);
`endif

      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 249) == 0) apply_reset();
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
         en = ($urandom_range(0, 9) != 0);
         lane_en = ($urandom_range(0, 3) == 0) ? NL'($urandom) : '1;
         for (int i = 0; i < NL; i++) begin
            gearbox_rdy[i] = ($urandom_range(0, 9) != 0);
            data_next[i]   = ($urandom_range(0, 9) != 0);
         end
         user_data = {$urandom, $urandom};
`ifdef AURORA_PATTERN_ERR_INJECT_EN
         err_inject = ($urandom_range(0, 19) == 0);
         err_lane   = 3'($urandom);
`endif
         step();
      end

      @(posedge clk40); #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
